pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 66 ++++++
 tb/tb_pc_sequencer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: four-phase instruction sequencer with IDLE/RUN/HALTED control and a retired-instruction counter
module pc_sequencer #(
    parameter int D  = 12,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [D-1:0]  start_addr,
    input  logic          jump,
    input  logic          branch_taken,
    input  logic          call,
    input  logic          ret,
    input  logic          halt,
    input  logic [D-1:0]  target,
    output logic [1:0]    stage,
    output logic [D-1:0]  pc,
    output logic          running,
    output logic          done,
    output logic [CW-1:0] retired
);
    typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;
    state_t        state, state_n;
    logic [1:0]    stage_n;
    logic [D-1:0]  pc_n;
    logic [CW-1:0] retired_n;
    logic          redirect;
    assign redirect = jump | branch_taken | call | ret;
    // Control inputs only matter on the writeback phase, where the next pc is chosen.
    always_comb begin
        state_n   = state;
        stage_n   = stage;
        pc_n      = pc;
        retired_n = retired;
        if (state != RUN) begin
            stage_n   = 2'b00;
            state_n   = start ? RUN : state;
            pc_n      = start ? start_addr : pc;
            retired_n = start ? '0 : retired;
        end else begin
            stage_n = stage + 2'd1;
            if (stage == 2'b11) begin
                retired_n = &retired ? retired : retired + CW'(1);
                state_n   = halt ? HALTED : RUN;
                pc_n      = halt ? pc : redirect ? target : pc + D'(1);
            end
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            stage   <= 2'b00;
            pc      <= '0;
            retired <= '0;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            stage   <= stage_n;
            pc      <= pc_n;
            retired <= retired_n;
            running <= state_n == RUN;
            done    <= state_n == HALTED;
        end
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: table, directed and random checks of pc_sequencer against a behavioural model
module tb_pc_sequencer;
    localparam int D = 12;
    logic clk = 1'b0;
    logic reset = 1'b0, start = 1'b0, jump = 1'b0, branch_taken = 1'b0, call = 1'b0, ret = 1'b0, halt = 1'b0;
    logic [D-1:0] start_addr = '0, target = '0;
    logic [1:0] stage, stage_s;
    logic [D-1:0] pc, pc_s;
    logic running, done, running_s, done_s;
    logic [15:0] retired;
    logic [2:0] retired_s;
    int n_checks = 0, n_fail = 0;
    int m_mode = 0, m_stage = 0, m_pc = 0, m_ret = 0, m_ret3 = 0;

    always #5 clk = ~clk;

    pc_sequencer dut (.clk(clk), .reset(reset), .start(start), .start_addr(start_addr), .jump(jump),
        .branch_taken(branch_taken), .call(call), .ret(ret), .halt(halt), .target(target),
        .stage(stage), .pc(pc), .running(running), .done(done), .retired(retired));
    pc_sequencer #(.D(12), .CW(3)) dut_s (.clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
        .jump(jump), .branch_taken(branch_taken), .call(call), .ret(ret), .halt(halt), .target(target),
        .stage(stage_s), .pc(pc_s), .running(running_s), .done(done_s), .retired(retired_s));

    typedef struct {
        logic rst; logic st; logic [11:0] sa; logic [4:0] ctl; logic [11:0] tgt;
        logic [1:0] e_stage; logic [11:0] e_pc; logic e_run; logic e_done; logic [15:0] e_ret;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic s, int sa, logic [4:0] c, int t, int es, int ep, logic er, logic ed, int ert);
        vec_t v;
        v.rst = r; v.st = s; v.sa = 12'(sa); v.ctl = c; v.tgt = 12'(t);
        v.e_stage = 2'(es); v.e_pc = 12'(ep); v.e_run = er; v.e_done = ed; v.e_ret = 16'(ert);
        return v;
    endfunction

    task automatic chk(string name, longint act, longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_ctl(logic [4:0] c, int t);
        {jump, branch_taken, call, ret, halt} = c;
        target = 12'(t);
    endtask

    // Reference: mode 0 idle, 1 run, 2 halted; an instruction completes every fourth running cycle.
    task automatic model_step();
        if (reset) begin
            m_mode = 0; m_stage = 0; m_pc = 0; m_ret = 0; m_ret3 = 0;
        end else if (m_mode != 1) begin
            if (start) begin
                m_mode = 1; m_pc = int'(start_addr); m_stage = 0; m_ret = 0; m_ret3 = 0;
            end
        end else if (m_stage == 3) begin
            m_stage = 0;
            m_ret = m_ret < 65535 ? m_ret + 1 : m_ret;
            m_ret3 = m_ret3 < 7 ? m_ret3 + 1 : m_ret3;
            if (halt) m_mode = 2;
            else if (jump || branch_taken || call || ret) m_pc = int'(target);
            else m_pc = (m_pc + 1) % (1 << D);
        end else m_stage++;
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        chk("stage", stage, m_stage);
        chk("pc", pc, m_pc);
        chk("running", running, m_mode == 1);
        chk("done", done, m_mode == 2);
        chk("retired", retired, m_ret);
        chk("retired_sat", retired_s, m_ret3);
        chk("pc_s", pc_s, m_pc);
        chk("stage_s", stage_s, m_stage);
        chk("flags_s", {running_s, done_s}, {running, done});
    endtask

    task automatic restart(int addr);
        set_ctl(5'b0, 0);
        reset = 1'b1; start = 1'b0; step();
        reset = 1'b0; start = 1'b1; start_addr = 12'(addr); step();
        start = 1'b0;
    endtask

    task automatic steps(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        tbl.push_back(mk(1, 0, 0, 5'b0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 'h010, 5'b0, 0, 0, 'h010, 1, 0, 0));
        // Controls and start held at non-writeback phases must be ignored.
        for (int k = 0; k < 12; k++)
            tbl.push_back(mk(0, k % 2 == 1, 'h7FF, (k % 4 == 3) ? 5'b0 : 5'b11111, 'h3AB,
                             (k + 1) % 4, 'h010 + (k + 1) / 4, 1, 0, (k + 1) / 4));
        foreach (tbl[i]) begin
            reset = tbl[i].rst; start = tbl[i].st; start_addr = tbl[i].sa;
            set_ctl(tbl[i].ctl, int'(tbl[i].tgt));
            step();
            chk("tbl_stage", stage, tbl[i].e_stage);
            chk("tbl_pc", pc, tbl[i].e_pc);
            chk("tbl_running", running, tbl[i].e_run);
            chk("tbl_done", done, tbl[i].e_done);
            chk("tbl_retired", retired, tbl[i].e_ret);
        end

        restart('h020);
        set_ctl(5'b10000, 'h005); steps(4);
        chk("jump_held_pc", pc, 'h005);
        restart('h020);
        step();
        set_ctl(5'b10000, 'h005); step();
        set_ctl(5'b0, 0); steps(2);
        chk("jump_stage1_pc", pc, 'h021);

        restart('h030);
        start = 1'b1; start_addr = 12'h777; step();
        start = 1'b0; chk("start_in_run_pc", pc, 'h030);
        steps(2);
        set_ctl(5'b00100, 'h100); step();
        chk("call_pc", pc, 'h100);
        set_ctl(5'b0, 0); steps(3);
        set_ctl(5'b00010, 'h031); step();
        chk("ret_pc", pc, 'h031);
        set_ctl(5'b00110, 'h200); steps(4);
        chk("call_ret_pc", pc, 'h200);

        restart('hFFF);
        set_ctl(5'b0, 0); steps(4);
        chk("wrap_pc", pc, 'h000);
        chk("wrap_running", running, 1);

        restart('h040);
        steps(3);
        set_ctl(5'b10001, 'h123); step();
        chk("halt_pc", pc, 'h040);
        chk("halt_done", done, 1);
        chk("halt_running", running, 0);
        chk("halt_retired", retired, 1);
        set_ctl(5'b0, 0); steps(3);
        chk("halted_stage", stage, 0);
        start = 1'b1; start_addr = 12'h000; step();
        start = 1'b0;
        chk("restart_running", running, 1);
        chk("restart_retired", retired, 0);

        restart('h055);
        steps(2);
        reset = 1'b1; start = 1'b1; start_addr = 12'h0AA; set_ctl(5'b10000, 'h111); step();
        reset = 1'b0; start = 1'b0; set_ctl(5'b0, 0);
        chk("rst_pc", pc, 0);
        chk("rst_stage", stage, 0);
        chk("rst_running", running, 0);
        chk("rst_retired", retired, 0);
        step();
        chk("idle_running", running, 0);

        restart('h000);
        steps(40);
        chk("sat_retired", retired, 10);
        chk("sat_retired_s", retired_s, 7);

        for (int i = 0; i < 3000; i++) begin
            reset = $urandom_range(0, 199) == 0;
            start = $urandom_range(0, 7) == 0;
            start_addr = 12'($urandom);
            jump = $urandom_range(0, 5) == 0;
            branch_taken = $urandom_range(0, 5) == 0;
            call = $urandom_range(0, 7) == 0;
            ret = $urandom_range(0, 7) == 0;
            halt = $urandom_range(0, 19) == 0;
            target = 12'($urandom);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
